// File: rtl/tour_cmd_seq.sv
// Command sequencer/arbiter between the UART path and the knight's-tour solver, feeding cmd_proc.
// Optional: define TOUR_CMD_ABORT_EN to let a UART 4'hF command abort a tour in progress.
//
// state  | meaning
// IDLE   | UART owns cmd_proc; cmd/cmd_rdy forwarded from UART_wrapper
// VERT   | vertical leg of move[mv_indx] offered to cmd_proc
// HOLD_V | vertical leg accepted, waiting for cmd_proc to finish it
// HORZ   | horizontal leg (move + fanfare) offered to cmd_proc
// HOLD_H | horizontal leg accepted, waiting for completion; then next move or IDLE
module tour_cmd_seq #(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  typedef enum logic [2:0] {IDLE, VERT, HOLD_V, HORZ, HOLD_H} state_t;

  localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

  state_t      state, state_nxt;
  logic [4:0]  mv_indx_nxt;
  logic [1:0]  dx_mag, dy_mag;
  logic        dx_neg, dy_neg, move_ok;
  logic [15:0] vert_leg, horz_leg;
  logic        abort;

`ifdef TOUR_CMD_ABORT_EN
  assign abort = (state != IDLE) && cmd_rdy_UART && (cmd_UART[15:12] == 4'hF);
`else
  assign abort = 1'b0;
`endif

  // One-hot move -> signed (dx,dy) as sign/magnitude pairs
  always_comb begin
    move_ok = 1'b1;
    {dx_neg, dx_mag, dy_neg, dy_mag} = 6'b0;
    case (move)
      8'h01:   {dx_neg, dx_mag, dy_neg, dy_mag} = 6'b0_01_0_10;
      8'h02:   {dx_neg, dx_mag, dy_neg, dy_mag} = 6'b1_01_0_10;
      8'h04:   {dx_neg, dx_mag, dy_neg, dy_mag} = 6'b1_10_0_01;
      8'h08:   {dx_neg, dx_mag, dy_neg, dy_mag} = 6'b1_10_1_01;
      8'h10:   {dx_neg, dx_mag, dy_neg, dy_mag} = 6'b1_01_1_10;
      8'h20:   {dx_neg, dx_mag, dy_neg, dy_mag} = 6'b0_01_1_10;
      8'h40:   {dx_neg, dx_mag, dy_neg, dy_mag} = 6'b0_10_1_01;
      8'h80:   {dx_neg, dx_mag, dy_neg, dy_mag} = 6'b0_10_0_01;
      default: move_ok = 1'b0;
    endcase
  end

  assign vert_leg = move_ok ? {4'h4, (dy_neg ? 8'h7F : 8'h00), 2'b00, dy_mag} : 16'h4000;
  assign horz_leg = move_ok ? {4'h5, (dx_neg ? 8'h3F : 8'hBF), 2'b00, dx_mag} : 16'h4000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mv_indx <= '0;
    end else begin
      state   <= state_nxt;
      mv_indx <= mv_indx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    mv_indx_nxt = mv_indx;
    cmd         = cmd_UART;
    cmd_rdy     = cmd_rdy_UART;
    resp        = 8'h5A;
    case (state)
      IDLE: begin
        resp = 8'hA5;
        if (start_tour) begin
          state_nxt   = VERT;
          mv_indx_nxt = '0;
        end
      end
      VERT: begin
        cmd     = vert_leg;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_nxt = HOLD_V;
      end
      HOLD_V: begin
        cmd     = vert_leg;
        cmd_rdy = 1'b0;
        if (send_resp) state_nxt = HORZ;
      end
      HORZ: begin
        cmd     = horz_leg;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_nxt = HOLD_H;
      end
      HOLD_H: begin
        cmd     = horz_leg;
        cmd_rdy = 1'b0;
        if (mv_indx == LAST_IDX) resp = 8'hA5;
        if (send_resp) begin
          if (mv_indx == LAST_IDX) begin
            state_nxt = IDLE;
          end else begin
            state_nxt   = VERT;
            mv_indx_nxt = mv_indx + 5'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt   = IDLE;
      mv_indx_nxt = '0;
    end
  end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Scoreboard bench for tour_cmd_seq: expected legs are queued at tour start and
// popped by a scripted cmd_proc model as each command is offered.
module tb_tour_cmd_seq;
  localparam int NUM_MOVES = 24;

  localparam logic [15:0] V_TAB [8] = '{16'h4002, 16'h4002, 16'h4001, 16'h47F1,
                                        16'h47F2, 16'h47F2, 16'h47F1, 16'h4001};
  localparam logic [15:0] H_TAB [8] = '{16'h5BF1, 16'h53F1, 16'h53F2, 16'h53F2,
                                        16'h53F1, 16'h5BF1, 16'h5BF2, 16'h5BF2};

  logic        clk = 1'b0, rst_n = 1'b0, start_tour = 1'b0;
  logic        cmd_rdy_UART = 1'b0, clr_cmd_rdy = 1'b0, send_resp = 1'b0;
  logic [15:0] cmd_UART = 16'h0000;
  logic [7:0]  move, resp;
  logic [4:0]  mv_indx;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic [7:0]  mv_tab [32];

  typedef struct packed {
    logic [15:0] cmd;
    logic [4:0]  idx;
    logic        last;
  } leg_t;

  leg_t exp_q[$];
  int   n_checks = 0, n_pass = 0, n_cmds = 0;
  bit   aborted;

  tour_cmd_seq #(.NUM_MOVES(NUM_MOVES)) dut (
    .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move), .mv_indx(mv_indx),
    .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp)
  );

  always #5 clk = ~clk;

  // Solver model: holds the move for whatever index is being issued
  assign move = mv_tab[mv_indx];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [15:0] ref_leg(input logic [7:0] mv, input bit horz);
    logic [15:0] r;
    r = 16'h4000;
    if ($onehot(mv)) begin
      for (int k = 0; k < 8; k++)
        if (mv[k]) r = horz ? H_TAB[k] : V_TAB[k];
    end
    return r;
  endfunction

  task automatic push_tour();
    for (int i = 0; i < NUM_MOVES; i++) begin
      exp_q.push_back('{cmd: ref_leg(mv_tab[i], 1'b0), idx: 5'(i), last: 1'b0});
      exp_q.push_back('{cmd: ref_leg(mv_tab[i], 1'b1), idx: 5'(i), last: (i == NUM_MOVES - 1)});
    end
  endtask

  task automatic start_pulse();
    @(negedge clk) start_tour = 1'b1;
    @(negedge clk) start_tour = 1'b0;
  endtask

  // cmd_proc model: accept one offered leg, optionally disturb it while held, then complete it
  task automatic serve_leg(input bit both, input bit poke, input logic [15:0] poke_cmd);
    leg_t e;
    int   w = 0;
    while (cmd_rdy !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (cmd_rdy !== 1'b1) begin
      chk("cmd_rdy_wait", 16'(cmd_rdy), 16'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      chk("sb_underflow", 16'(exp_q.size()), 16'd1);
      return;
    end
    e = exp_q.pop_front();
    n_cmds++;
    chk("leg_cmd", cmd, e.cmd);
    chk("leg_idx", 16'(mv_indx), 16'(e.idx));
    clr_cmd_rdy = 1'b1;
    send_resp   = both;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    chk("rdy_drop", 16'(cmd_rdy), 16'd0);
    chk("hold_cmd", cmd, e.cmd);
    if (poke) begin
      cmd_UART     = poke_cmd;
      cmd_rdy_UART = 1'b1;
      start_tour   = 1'b1;
      @(negedge clk);
      start_tour = 1'b0;
`ifdef TOUR_CMD_ABORT_EN
      if (poke_cmd[15:12] == 4'hF) begin
        chk("abort_idx", 16'(mv_indx), 16'd0);
        chk("abort_cmd", cmd, poke_cmd);
        chk("abort_rdy", 16'(cmd_rdy), 16'd1);
        chk("abort_resp", 16'(resp), 16'h00A5);
        cmd_rdy_UART = 1'b0;
        cmd_UART     = 16'h0000;
        aborted      = 1'b1;
        return;
      end
`endif
      chk("uart_blocked", 16'(cmd_rdy), 16'd0);
      chk("poke_idx", 16'(mv_indx), 16'(e.idx));
      chk("poke_cmd", cmd, e.cmd);
      cmd_rdy_UART = 1'b0;
      cmd_UART     = 16'h0000;
    end
    @(negedge clk);
    send_resp = 1'b1;
    #1;
    chk("resp", 16'(resp), e.last ? 16'h00A5 : 16'h005A);
    @(negedge clk);
    send_resp = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mv_tab[i] = 8'h01 << (i % 8);
    mv_tab[5]  = 8'h03;
    mv_tab[13] = 8'h00;

    // Reset state
    #1;
    chk("rst_idx", 16'(mv_indx), 16'd0);
    chk("rst_rdy", 16'(cmd_rdy), 16'd0);
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_resp", 16'(resp), 16'h00A5);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;

    // UART pass-through
    @(negedge clk);
    cmd_UART = 16'h2000;
    cmd_rdy_UART = 1'b1;
    #1;
    chk("uart_cmd", cmd, 16'h2000);
    chk("uart_rdy", 16'(cmd_rdy), 16'd1);
    send_resp = 1'b1;
    #1;
    chk("uart_resp", 16'(resp), 16'h00A5);
    @(negedge clk);
    cmd_rdy_UART = 1'b0;
    send_resp    = 1'b0;
    cmd_UART     = 16'h0000;
    #1;
    chk("uart_rdy_off", 16'(cmd_rdy), 16'd0);

    // Full tour with same-cycle clr/send on one leg and a UART/start_tour poke on another
    n_cmds = 0;
    push_tour();
    start_pulse();
    for (int leg = 0; leg < 2 * NUM_MOVES; leg++)
      serve_leg(leg == 2, leg == 4, 16'h1234);
    chk("tour_cmds", 16'(n_cmds), 16'd48);
    chk("sb_left", 16'(exp_q.size()), 16'd0);
    @(negedge clk);
    chk("end_rdy", 16'(cmd_rdy), 16'd0);
    chk("end_resp", 16'(resp), 16'h00A5);
    chk("end_idx", 16'(mv_indx), 16'(NUM_MOVES - 1));

    // UART 4'hF command while held at mv_indx 3
    n_cmds  = 0;
    aborted = 1'b0;
    exp_q.delete();
    push_tour();
    start_pulse();
    for (int leg = 0; leg < 2 * NUM_MOVES && !aborted; leg++)
      serve_leg(1'b0, leg == 6, 16'hF000);
`ifdef TOUR_CMD_ABORT_EN
    chk("abort_seen", 16'(aborted), 16'd1);
`else
    chk("noabort_cmds", 16'(n_cmds), 16'd48);
`endif
    exp_q.delete();
    @(negedge clk);
    chk("post_t2_rdy", 16'(cmd_rdy), 16'd0);

    // Async reset while offering the horizontal leg of move 7
    push_tour();
    start_pulse();
    for (int leg = 0; leg < 15; leg++) serve_leg(1'b0, 1'b0, 16'h0000);
    for (int w = 0; w < 20 && cmd_rdy !== 1'b1; w++) @(negedge clk);
    chk("horz7_idx", 16'(mv_indx), 16'd7);
    chk("horz7_cmd", cmd, ref_leg(mv_tab[7], 1'b1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_idx", 16'(mv_indx), 16'd0);
    chk("arst_rdy", 16'(cmd_rdy), 16'd0);
    chk("arst_cmd", cmd, 16'h0000);
    chk("arst_resp", 16'(resp), 16'h00A5);
    cmd_UART     = 16'h2000;
    cmd_rdy_UART = 1'b1;
    #1;
    chk("arst_uart_rdy", 16'(cmd_rdy), 16'd1);
    chk("arst_uart_cmd", cmd, 16'h2000);
    @(negedge clk);
    rst_n        = 1'b1;
    cmd_rdy_UART = 1'b0;
    cmd_UART     = 16'h0000;
    @(negedge clk);
    chk("post_rst_rdy", 16'(cmd_rdy), 16'd0);
    chk("post_rst_idx", 16'(mv_indx), 16'd0);
    exp_q.delete();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tour_cmd_seq.md
Name: tour_cmd_seq

Overview:
- Command sequencer and arbiter between the UART command path and the knight's-tour solver, upstream of cmd_proc.
- In UART mode, UART commands pass straight to cmd_proc.
- On start_tour, it takes ownership of cmd_proc's command port, splits each one-hot knight move into a vertical leg and a horizontal leg, and issues both as move commands.
- It also selects the response byte returned to RemoteComm.

Parameters:
NUM_MOVES, 24, number of knight moves in a tour (move index runs 0..NUM_MOVES-1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start_tour  in  1  one-cycle pulse from the tour solver; begin sequencing moves at index 0
move  in  8  one-hot knight move for the current mv_indx, supplied by the solver
mv_indx  out  5  index of the move currently being issued
cmd_UART  in  16  command from UART_wrapper
cmd_rdy_UART  in  1  UART command valid
cmd  out  16  command to cmd_proc
cmd_rdy  out  1  command valid to cmd_proc
clr_cmd_rdy  in  1  cmd_proc consumed the command
send_resp  in  1  cmd_proc finished the command
resp  out  8  response byte to UART_wrapper

Behaviour:
- Command encoding:
  - cmd[15:12]: 4'h2 = calibrate, 4'h4 = move, 4'h5 = move then fanfare.
  - cmd[11:4] = heading: north 8'h00, west 8'h3F, south 8'h7F, east 8'hBF.
  - cmd[3:0] = number of squares.
- Move decode (bit: dx,dy):
  - b0 +1,+2; b1 -1,+2; b2 -2,+1; b3 -2,-1; b4 -1,-2; b5 +1,-2; b6 +2,-1; b7 +2,+1.
  - Vertical leg: opcode 4'h4, heading N if dy>0 else S, squares = |dy|.
  - Horizontal leg: opcode 4'h5, heading E if dx>0 else W, squares = |dx|.
  - A non-one-hot move yields cmd = 16'h4000 (zero-square move); no error flag.
- States: IDLE, VERT, HOLD_V, HORZ, HOLD_H.
  - IDLE: cmd = cmd_UART, cmd_rdy = cmd_rdy_UART, clr_cmd_rdy is forwarded to the UART side by UART_wrapper. start_tour -> VERT, mv_indx <= 0.
  - VERT: cmd = vertical leg, cmd_rdy = 1. clr_cmd_rdy -> HOLD_V; cmd_rdy drops the cycle after clr_cmd_rdy.
  - HOLD_V: cmd_rdy = 0, cmd holds the vertical leg. send_resp -> HORZ.
  - HORZ: cmd = horizontal leg, cmd_rdy = 1. clr_cmd_rdy -> HOLD_H.
  - HOLD_H: send_resp and mv_indx == NUM_MOVES-1 -> IDLE. Otherwise, send_resp -> mv_indx+1, then VERT.
- move is sampled combinationally while in VERT/HORZ. The solver holds move stable for a given mv_indx.
- resp:
  - 8'hA5 in IDLE.
  - 8'hA5 in HOLD_H when mv_indx == NUM_MOVES-1.
  - 8'h5A otherwise.
  - Combinational; valid whenever send_resp is high.
- Boundary conditions:
  - start_tour while not IDLE: ignored.
  - clr_cmd_rdy and send_resp arriving in the same cycle in VERT: only clr_cmd_rdy is acted on; send_resp is ignored.
  - UART cmd_rdy_UART during a tour: not forwarded, and stays pending in UART_wrapper.
  - mv_indx increments only in HOLD_H on send_resp; it never wraps past NUM_MOVES-1.
- Reset (async, any state): state IDLE, mv_indx 0. cmd/cmd_rdy then reflect the UART path, so both read 0 if the UART is idle.
- Latency: every state transition takes one clk after the qualifying input.

Optional Feature:
- TOUR_CMD_ABORT_EN defined:
  - In any tour state, cmd_rdy_UART with cmd_UART[15:12] == 4'hF forces IDLE and clears mv_indx to 0.
  - Abort has priority over send_resp and clr_cmd_rdy in the same cycle.
  - The abort command is then visible on cmd in IDLE.
- Undefined: UART commands are ignored during a tour, as in Behaviour.

Test Plan:
- Reset; in IDLE, drive cmd_UART = 16'h2000 with cmd_rdy_UART = 1 -> cmd = 16'h2000, cmd_rdy = 1. Pulse send_resp -> resp = 8'hA5.
- start_tour with move = 8'h01 -> cmd = 16'h4002, cmd_rdy = 1. clr_cmd_rdy -> cmd_rdy = 0 next cycle. send_resp -> resp = 8'h5A, then cmd = 16'h5BF1.
- move = 8'h08 -> legs 16'h47F1 then 16'h53F2. move = 8'h10 -> legs 16'h47F2 then 16'h53F1.
- Full tour with NUM_MOVES = 24 and a scripted cmd_proc model -> mv_indx steps 0..23, exactly 48 commands, resp = 8'hA5 only on the final send_resp, then back to IDLE.
- Assert rst_n low while in HORZ at mv_indx = 7 -> immediately state IDLE, mv_indx = 0, cmd_rdy follows the UART path.
- With TOUR_CMD_ABORT_EN, send 16'hF000 during HOLD_V at mv_indx = 3 -> IDLE next cycle, mv_indx = 0, cmd = 16'hF000. Without the macro -> tour continues unaffected.
